// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Host-loadable program memory with a valid/ready fetch sequencer.
//            Optional macro FETCH_PERF_EN adds fetch/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int INSTR_W = 14,
  parameter int DEPTH   = 32,
  parameter int WRAP    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [INSTR_W-1:0]         load_data,
  input  logic                       load_done,
  input  logic                       run_start,
  input  logic                       halt_req,
  input  logic                       br_valid,
  input  logic [$clog2(DEPTH)-1:0]   br_target,
  input  logic                       instr_ready,
  output logic                       instr_valid,
  output logic [INSTR_W-1:0]         instr,
  output logic [$clog2(DEPTH)-1:0]   instr_pc,
  output logic [$clog2(DEPTH):0]     prog_len,
`ifdef FETCH_PERF_EN
  output logic [15:0]                fetch_cnt,
  output logic [15:0]                stall_cnt,
`endif
  output logic [1:0]                 state,
  output logic                       err
);

  localparam int PC_W  = $clog2(DEPTH);
  localparam int LEN_W = PC_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_HALT = 2'b11
  } state_e;

  state_e               state_q;
  logic [INSTR_W-1:0]   mem_q [DEPTH];
  logic [LEN_W-1:0]     wptr_q;
  logic [LEN_W-1:0]     fpc_q;
  logic [LEN_W-1:0]     prog_len_q;
  logic [INSTR_W-1:0]   instr_q;
  logic [PC_W-1:0]      instr_pc_q;
  logic                 instr_valid_q;
  logic                 err_q;

  logic                 mem_we_d;
  logic                 slot_open_d;
  logic [LEN_W-1:0]     br_target_d;

  assign mem_we_d    = (state_q == ST_LOAD) && load_valid && (wptr_q < DEPTH_L);
  assign slot_open_d = !instr_valid_q || instr_ready;
  assign br_target_d = {1'b0, br_target};

  // Program storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[wptr_q[PC_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wptr_q        <= '0;
      fpc_q         <= '0;
      prog_len_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (load_start) begin
            state_q <= ST_LOAD;
            wptr_q  <= '0;
            err_q   <= 1'b0;
          end else if (run_start && (prog_len_q != '0)) begin
            state_q <= ST_RUN;
            fpc_q   <= '0;
          end
        end

        ST_LOAD: begin
          if (load_valid) begin
            if (mem_we_d) wptr_q <= wptr_q + 1'b1;
            else          err_q  <= 1'b1;
          end
          // A word written on the load_done cycle still counts toward the length.
          if (load_done) begin
            state_q    <= ST_IDLE;
            prog_len_q <= mem_we_d ? wptr_q + 1'b1 : wptr_q;
          end
        end

        ST_RUN: begin
          if (halt_req) begin
            instr_valid_q <= 1'b0;
            state_q       <= ST_HALT;
          end else if (br_valid) begin
            if (br_target_d < prog_len_q) begin
              instr_q       <= mem_q[br_target];
              instr_pc_q    <= br_target;
              instr_valid_q <= 1'b1;
              fpc_q         <= br_target_d + 1'b1;
            end else begin
              err_q         <= 1'b1;
              instr_valid_q <= 1'b0;
              state_q       <= ST_HALT;
            end
          end else if (slot_open_d) begin
            if (fpc_q < prog_len_q) begin
              instr_q       <= mem_q[fpc_q[PC_W-1:0]];
              instr_pc_q    <= fpc_q[PC_W-1:0];
              instr_valid_q <= 1'b1;
              fpc_q         <= fpc_q + 1'b1;
            end else if (WRAP != 0) begin
              instr_q       <= mem_q[0];
              instr_pc_q    <= '0;
              instr_valid_q <= 1'b1;
              fpc_q         <= LEN_W'(1);
            end else begin
              instr_valid_q <= 1'b0;
              state_q       <= ST_HALT;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (run_start) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (instr_valid_q) begin
      if (instr_ready && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (!instr_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign prog_len    = prog_len_q;
  assign state       = state_q;
  assign err         = err_q;

endmodule

`default_nettype wire
